// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcode/func constants, FSM encoding and decode helper for alu_issue_seq
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // R-type func codes whose result is written back to R[rd]
    function automatic logic rtype_func_ok(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - 32x32 register file, two operand reads, one debug read, one write
//
// Ports:
//   clk, rst            clock, asynchronous active-high clear of all entries
//   raddr_a / rdata_a   operand A read (combinational)
//   raddr_b / rdata_b   operand B read (combinational)
//   dbg_raddr/dbg_rdata debug read (combinational)
//   we, waddr, wdata    synchronous write; index 0 is discarded
module alu_issue_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // R0 is hardwired: reads of index 0 never depend on storage
    assign rdata_a   = (raddr_a   == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b   = (raddr_b   == 5'd0) ? 32'd0 : regs[raddr_b];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - instruction issue sequencer driving a combinational ALU
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   instr_valid, instr, instr_ready  instruction handshake (ready only when idle)
//   alu_opcode, alu_func, alu_a/b    registered operands/controls to the ALU
//   alu_result, alu_zero             ALU outputs, sampled on the last EXEC cycle
//   done_valid, done_result          one-cycle completion pulse and captured result
//   branch_taken, illegal            beq outcome / unsupported instruction flag
//   dbg_we, dbg_waddr, dbg_wdata     debug register write, honoured only when idle
//   dbg_raddr, dbg_rdata             combinational debug register read
module alu_issue_seq
    import alu_issue_pkg::*;
#(
    parameter int EXEC_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        done_valid,
    output logic [31:0] done_result,
    output logic        branch_taken,
    output logic        illegal,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_waddr,
    input  logic [31:0] dbg_wdata,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    localparam logic [7:0] EXEC_LAST = 8'(EXEC_WAIT - 1);

    state_t      state, state_next;
    logic [31:0] instr_q;
    logic [7:0]  exec_cnt;
    logic [31:0] result_q;
    logic        zero_q;
    logic [31:0] rdata_a, rdata_b;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  q_opcode, q_func;
    logic        exec_last;

    assign q_opcode  = instr_q[31:26];
    assign q_func    = instr_q[5:0];
    assign exec_last = (exec_cnt == EXEC_LAST);

    alu_issue_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a   (instr_q[25:21]),
        .rdata_a   (rdata_a),
        .raddr_b   (instr_q[20:16]),
        .rdata_b   (rdata_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            instr_q    <= 32'd0;
            exec_cnt   <= 8'd0;
            result_q   <= 32'd0;
            zero_q     <= 1'b0;
            alu_opcode <= 6'd0;
            alu_func   <= 6'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
        end else begin
            state <= state_next;
            if (instr_valid && instr_ready) begin
                instr_q <= instr;
            end
            if (state == ST_READ) begin
                alu_opcode <= q_opcode;
                // lw uses the ALU purely as an address adder
                alu_func   <= (q_opcode == OP_LW) ? 6'd0 : q_func;
                alu_a      <= rdata_a;
                alu_b      <= (q_opcode == OP_LW) ? {{16{instr_q[15]}}, instr_q[15:0]} : rdata_b;
                exec_cnt   <= 8'd0;
            end
            if (state == ST_EXEC) begin
                exec_cnt <= exec_cnt + 8'd1;
                if (exec_last) begin
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        instr_ready  = 1'b0;
        done_valid   = 1'b0;
        done_result  = 32'd0;
        branch_taken = 1'b0;
        illegal      = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = dbg_waddr;
        rf_wdata     = dbg_wdata;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                rf_we       = dbg_we;
                if (instr_valid) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: begin
                if (exec_last) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                done_valid = 1'b1;
                state_next = ST_IDLE;
                if (q_opcode == OP_RTYPE && rtype_func_ok(q_func)) begin
                    done_result = result_q;
                    rf_we       = 1'b1;
                    rf_waddr    = instr_q[15:11];
                    rf_wdata    = result_q;
                end else if (q_opcode == OP_BEQ) begin
                    done_result  = result_q;
                    branch_taken = zero_q;
                end else if (q_opcode == OP_LW) begin
                    done_result = result_q;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - scoreboard bench for alu_issue_seq with a behavioural ALU in the loop
module tb_alu_issue_seq;

    localparam int EW = 1;

    logic        clk, rst;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [5:0]  alu_opcode, alu_func;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        done_valid, branch_taken, illegal;
    logic [31:0] done_result;
    logic        dbg_we;
    logic [4:0]  dbg_waddr, dbg_raddr;
    logic [31:0] dbg_wdata, dbg_rdata;

    alu_issue_seq #(.EXEC_WAIT(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_opcode   (alu_opcode),
        .alu_func     (alu_func),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .done_valid   (done_valid),
        .done_result  (done_result),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .dbg_we       (dbg_we),
        .dbg_waddr    (dbg_waddr),
        .dbg_wdata    (dbg_wdata),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
    );

    // Behavioural stand-in for Alu_Top
    always_comb begin
        alu_result = 32'hBAD0BAD0;
        case (alu_opcode)
            6'h00: begin
                case (alu_func)
                    6'h20: alu_result = alu_a + alu_b;
                    6'h22: alu_result = alu_a - alu_b;
                    6'h24: alu_result = alu_a & alu_b;
                    6'h25: alu_result = alu_a | alu_b;
                    6'h2A: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
                    default: alu_result = 32'hBAD0BAD0;
                endcase
            end
            6'h04: alu_result = alu_a - alu_b;
            6'h23: alu_result = alu_a + alu_b;
            default: alu_result = 32'hBAD0BAD0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t exp_next;
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;
    int   prev_acc = -1;
    bit   chk_gap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Accepts push the pending expectation; completions pop and compare
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                if (chk_gap && prev_acc >= 0) chk("accept_gap", 32'(cyc - prev_acc), 32'(3 + EW));
                prev_acc = cyc;
                acc_cyc  = cyc;
                acc_cnt++;
                sb.push_back(exp_next);
            end
            if (done_valid) begin
                done_cnt++;
                chk("latency", 32'(cyc - acc_cyc), 32'(2 + EW));
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_result", done_result, e.res);
                    chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.br});
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic dbg_read(input string tag, input logic [4:0] a, input logic [31:0] expv);
        dbg_raddr = a;
        #1;
        chk(tag, dbg_rdata, expv);
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] er, input logic eb, input logic ei);
        int start;
        start = done_cnt;
        exp_next = '{res: er, br: eb, ill: ei};
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        dbg_we = 1'b0;
        for (int i = 0; i < 50 && done_cnt == start; i++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt == start) chk("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int start;
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0;
        dbg_we = 1'b0; dbg_waddr = 5'd0; dbg_wdata = 32'd0; dbg_raddr = 5'd5;
        exp_next = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        dbg_read("rst_r5", 5'd5, 32'd0);
        chk("rst_alu_opcode", {26'd0, alu_opcode}, 32'd0);
        chk("rst_alu_func", {26'd0, alu_func}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("rst_done_result", done_result, 32'd0);
        chk("rst_branch", {31'd0, branch_taken}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);

        dbg_write(5'd1, 32'h2222);
        dbg_write(5'd2, 32'h1111);
        dbg_write(5'd0, 32'hDEAD);
        dbg_read("dbg_r0", 5'd0, 32'd0);
        dbg_read("dbg_r1", 5'd1, 32'h2222);

        send(32'h00221820, 32'h3333, 1'b0, 1'b0);           // add r3,r1,r2
        chk("add_opcode", {26'd0, alu_opcode}, 32'h00);
        chk("add_func", {26'd0, alu_func}, 32'h20);
        chk("add_a", alu_a, 32'h2222);
        chk("add_b", alu_b, 32'h1111);
        dbg_read("add_r3", 5'd3, 32'h3333);

        send(32'h10210004, 32'h0, 1'b1, 1'b0);              // beq r1,r1
        chk("beq_opcode", {26'd0, alu_opcode}, 32'h04);
        dbg_read("beq_r1", 5'd1, 32'h2222);
        dbg_read("beq_r3", 5'd3, 32'h3333);
        send(32'h10220004, 32'h1111, 1'b0, 1'b0);           // beq r1,r2
        dbg_read("beq_r2", 5'd2, 32'h1111);

        send(32'h0041202A, 32'd1, 1'b0, 1'b0);              // slt r4,r2,r1
        dbg_read("slt_r4", 5'd4, 32'd1);
        send(32'h00220024, 32'd0, 1'b0, 1'b0);              // and r0,r1,r2
        dbg_read("and_r0", 5'd0, 32'd0);

        send(32'h8C221000, 32'h3222, 1'b0, 1'b0);           // lw: rs=1, imm=0x1000
        chk("lw_b", alu_b, 32'h00001000);
        chk("lw_func", {26'd0, alu_func}, 32'd0);
        dbg_read("lw_r2", 5'd2, 32'h1111);

        send(32'hFC000000, 32'd0, 1'b0, 1'b1);              // opcode 0x3F
        send(32'h00221821, 32'd0, 1'b0, 1'b1);              // unsupported func into r3
        dbg_read("illfunc_r3", 5'd3, 32'h3333);

        dbg_we = 1'b1; dbg_waddr = 5'd7; dbg_wdata = 32'h7777;
        send(32'h00E24020, 32'h8888, 1'b0, 1'b0);           // add r8,r7,r2 with same-cycle debug write
        dbg_read("dbg_accept_r7", 5'd7, 32'h7777);
        dbg_read("dbg_accept_r8", 5'd8, 32'h8888);

        // Abort add r5,r1,r2 in EXEC
        exp_next = '{res: 32'h3333, br: 1'b0, ill: 1'b0};
        instr = 32'h00222820;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        start = done_cnt;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
        repeat (6) tick();
        chk("abort_no_done", 32'(done_cnt - start), 32'd0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);
        dbg_read("abort_r5", 5'd5, 32'd0);
        dbg_read("abort_r1_cleared", 5'd1, 32'd0);

        // Back-to-back stream of add r6,r1,r2
        dbg_write(5'd1, 32'h2222);
        dbg_write(5'd2, 32'h1111);
        exp_next = '{res: 32'h3333, br: 1'b0, ill: 1'b0};
        instr = 32'h00223020;
        start = done_cnt;
        prev_acc = -1;
        chk_gap = 1'b1;
        instr_valid = 1'b1;
        repeat (20) tick();
        instr_valid = 1'b0;
        chk_gap = 1'b0;
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        chk("stream_drained", 32'(sb.size()), 32'd0);
        chk("stream_done_count", 32'(done_cnt - start), 32'd5);
        dbg_read("stream_r6", 5'd6, 32'h3333);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
